// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its write scoreboard.
package regfile_pkg;

   localparam int NUM_REGS_DEF = 32;
   localparam int ADDR_W_DEF   = 5;
   localparam int DATA_W_DEF   = 32;
   localparam int CNT_W_DEF    = 2;
   localparam int REG_ZERO     = 0;

   // Helpers work on vectors padded to these widths so one function fits every instance.
   localparam int MAX_PORTS   = 8;
   localparam int MAX_ADDR_W  = 8;
   localparam int MATCH_W     = 4;

   function automatic logic [MATCH_W-1:0] count_matches(
      input logic [MAX_ADDR_W-1:0]           addr,
      input logic [MAX_PORTS-1:0]            wr_en,
      input logic [MAX_PORTS*MAX_ADDR_W-1:0] wr_addr
   );
      logic [MATCH_W-1:0] n;
      n = '0;
      for (int k = 0; k < MAX_PORTS; k++) begin
         if (wr_en[k] && (wr_addr[k*MAX_ADDR_W +: MAX_ADDR_W] == addr)) begin
            n = n + MATCH_W'(1);
         end
      end
      return n;
   endfunction

   // True for a real, writable register (not reg 0, not beyond the array).
   function automatic logic addr_tracked(
      input logic [MAX_ADDR_W-1:0] addr,
      input int                    num_regs
   );
      return (addr != MAX_ADDR_W'(REG_ZERO)) && (int'(addr) < num_regs);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// In-flight write scoreboard: per-register counters, issue acceptance and pending flags.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   input  logic                     issue_valid,
   input  logic [ADDR_W-1:0]        issue_addr,
   output logic                     issue_ready,
   output logic [NUM_RD-1:0]        rd_pending
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]              cnt     [NUM_REGS];
   logic [CNT_W-1:0]              cnt_nxt [NUM_REGS];
   logic [MATCH_W-1:0]            dec     [NUM_REGS];
   logic [MAX_PORTS-1:0]          we_pad;
   logic [MAX_PORTS*MAX_ADDR_W-1:0] wa_pad;
   logic                          accept;

   always_comb begin
      we_pad = '0;
      wa_pad = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         we_pad[k] = wr_en[k];
         wa_pad[k*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(wr_addr[k*ADDR_W +: ADDR_W]);
      end
   end

   always_comb begin
      issue_ready = 1'b0;
      if (!rst) begin
         if (issue_addr == ADDR_W'(REG_ZERO)) begin
            issue_ready = 1'b1;
         end else if (addr_tracked(MAX_ADDR_W'(issue_addr), NUM_REGS)) begin
            issue_ready = (cnt[issue_addr] != CNT_MAX);
         end
      end
   end

   assign accept = issue_valid && issue_ready;

   // Net change is +1 for an accepted issue minus one per matching writeback, floored at 0.
   always_comb begin
      int n;
      n = 0;
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_nxt[r] = '0;
         dec[r]     = '0;
      end
      for (int r = 1; r < NUM_REGS; r++) begin
         dec[r] = count_matches(MAX_ADDR_W'(r), we_pad, wa_pad);
         n = int'(cnt[r]) - int'(dec[r]);
         if (accept && (issue_addr == ADDR_W'(r))) begin
            n = n + 1;
         end
         cnt_nxt[r] = (n < 0) ? '0 : CNT_W'(n);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= cnt_nxt[r];
         end
      end
   end

   always_comb begin
      logic [ADDR_W-1:0] a;
      a = '0;
      rd_pending = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         a = rd_addr[p*ADDR_W +: ADDR_W];
         if (addr_tracked(MAX_ADDR_W'(a), NUM_REGS)) begin
            if (BYPASS != 0) begin
               rd_pending[p] = (int'(cnt[a]) > int'(dec[a]));
            end else begin
               rd_pending[p] = (cnt[a] != '0);
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write scoreboard; reg 0 reads as zero.
// Optional debug read port enabled by REGFILE_DEBUG_PORT_EN.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pending,
   input  logic                     issue_valid,
   input  logic [ADDR_W-1:0]        issue_addr,
   output logic                     issue_ready
`ifdef REGFILE_DEBUG_PORT_EN
   ,
   input  logic [ADDR_W-1:0]        dbg_addr,
   output logic [DATA_W-1:0]        dbg_data
`endif
);

   logic [DATA_W-1:0]               mem [NUM_REGS];
   logic [MAX_PORTS-1:0]            we_pad;
   logic [MAX_PORTS*MAX_ADDR_W-1:0] wa_pad;

   always_comb begin
      we_pad = '0;
      wa_pad = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         we_pad[k] = wr_en[k];
         wa_pad[k*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(wr_addr[k*ADDR_W +: ADDR_W]);
      end
   end

   // Ascending port order so the highest-numbered port's nonblocking write lands last.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            mem[r] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && addr_tracked(MAX_ADDR_W'(wr_addr[k*ADDR_W +: ADDR_W]), NUM_REGS)) begin
               mem[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_comb begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      a = '0;
      v = '0;
      rd_data = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         a = rd_addr[p*ADDR_W +: ADDR_W];
         v = '0;
         if (addr_tracked(MAX_ADDR_W'(a), NUM_REGS)) begin
            v = mem[a];
            if ((BYPASS != 0) && (count_matches(MAX_ADDR_W'(a), we_pad, wa_pad) != '0)) begin
               for (int k = 0; k < NUM_WR; k++) begin
                  if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == a)) begin
                     v = wr_data[k*DATA_W +: DATA_W];
                  end
               end
            end
         end
         rd_data[p*DATA_W +: DATA_W] = v;
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .CNT_W    (CNT_W),
      .BYPASS   (BYPASS)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .rd_addr     (rd_addr),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .issue_ready (issue_ready),
      .rd_pending  (rd_pending)
   );

`ifdef REGFILE_DEBUG_PORT_EN
   // Committed state only: samples storage before this edge's writes land.
   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_data <= '0;
      end else if (addr_tracked(MAX_ADDR_W'(dbg_addr), NUM_REGS)) begin
         dbg_data <= mem[dbg_addr];
      end else begin
         dbg_data <= '0;
      end
   end
`else
   // Debug read port not built.
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: one bypassing 32-reg instance and one non-bypassing 24-reg instance share stimulus.
module tb_regfile_mp_sb;

   logic        clk;
   logic        rst;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [9:0]  rd_addr;
   logic        issue_valid;
   logic [4:0]  issue_addr;

   logic [63:0] rd_data_b, rd_data_nb;
   logic [1:0]  rd_pending_b, rd_pending_nb;
   logic        issue_ready_b, issue_ready_nb;
`ifdef REGFILE_DEBUG_PORT_EN
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data_b, dbg_data_nb;
`endif

   int n_checks = 0;
   int n_errors = 0;

   regfile_mp_sb #(.NUM_REGS(32), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rd_pending_b),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready_b)
`ifdef REGFILE_DEBUG_PORT_EN
      , .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
`endif
   );

   regfile_mp_sb #(.NUM_REGS(24), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_pending(rd_pending_nb),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready_nb)
`ifdef REGFILE_DEBUG_PORT_EN
      , .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en       = '0;
      issue_valid = 1'b0;
   endtask

   task automatic set_wr(input int k, input logic [4:0] a, input logic [31:0] d);
      wr_en[k]            = 1'b1;
      wr_addr[k*5 +: 5]   = a;
      wr_data[k*32 +: 32] = d;
   endtask

   task automatic set_rd(input int p, input logic [4:0] a);
      rd_addr[p*5 +: 5] = a;
   endtask

   initial begin
      rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      issue_valid = 1'b0; issue_addr = 5'd5;
`ifdef REGFILE_DEBUG_PORT_EN
      dbg_addr = '0;
`endif
      step();
      check("rst_ready_b", 32'(issue_ready_b), 32'd0);
      check("rst_ready_nb", 32'(issue_ready_nb), 32'd0);
      rst = 1'b0;

      // Reset discards a committed value
      set_wr(0, 5'd5, 32'hDEAD); set_rd(0, 5'd5); #1;
      check("t1_bypass_b", rd_data_b[31:0], 32'hDEAD);
      check("t1_nobypass_nb", rd_data_nb[31:0], 32'h0);
      step(); idle(); #1;
      check("t1_commit_b", rd_data_b[31:0], 32'hDEAD);
      check("t1_commit_nb", rd_data_nb[31:0], 32'hDEAD);
      rst = 1'b1; issue_valid = 1'b1; issue_addr = 5'd5; #1;
      check("t1_ready_in_rst", 32'(issue_ready_b), 32'd0);
      step(); rst = 1'b0; idle(); #1;
      check("t1_after_rst_b", rd_data_b[31:0], 32'h0);
      check("t1_after_rst_nb", rd_data_nb[31:0], 32'h0);
      check("t1_pend_after_rst", 32'(rd_pending_b[0]), 32'd0);

      // Write priority and bypass
      set_wr(0, 5'd3, 32'h11); set_wr(1, 5'd3, 32'h22); set_rd(0, 5'd3); #1;
      check("t2_bypass_hi_b", rd_data_b[31:0], 32'h22);
      check("t2_old_nb", rd_data_nb[31:0], 32'h0);
      step(); idle(); #1;
      check("t2_commit_b", rd_data_b[31:0], 32'h22);
      check("t2_commit_nb", rd_data_nb[31:0], 32'h22);

      // Register zero
      set_wr(0, 5'd0, 32'hFFFF_FFFF); issue_valid = 1'b1; issue_addr = 5'd0; set_rd(1, 5'd0); #1;
      check("t3_ready0", 32'(issue_ready_b), 32'd1);
      check("t3_rd0_bypass", rd_data_b[63:32], 32'h0);
      check("t3_pend0_b", 32'(rd_pending_b[1]), 32'd0);
      step(); idle(); #1;
      check("t3_rd0_b", rd_data_b[63:32], 32'h0);
      check("t3_rd0_nb", rd_data_nb[63:32], 32'h0);
      check("t3_pend0_after", 32'(rd_pending_nb[1]), 32'd0);

      // Counter saturation at 3
      set_rd(0, 5'd7); issue_addr = 5'd7;
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1'b1; #1;
         check("t4_ready_fill", 32'(issue_ready_b), 32'd1);
         step();
      end
      check("t4_ready_full_b", 32'(issue_ready_b), 32'd0);
      check("t4_ready_full_nb", 32'(issue_ready_nb), 32'd0);
      check("t4_pend_full", 32'(rd_pending_b[0]), 32'd1);
      issue_valid = 1'b0; set_wr(0, 5'd7, 32'h77); #1;
      check("t4_pend_wb_b", 32'(rd_pending_b[0]), 32'd1);
      step(); idle(); issue_valid = 1'b1; #1;
      check("t4_ready_after_wb", 32'(issue_ready_b), 32'd1);
      check("t4_pend_after_wb", 32'(rd_pending_nb[0]), 32'd1);
      issue_valid = 1'b0; set_wr(0, 5'd7, 32'h78); set_wr(1, 5'd7, 32'h79); #1;
      check("t4_pend_drain_b", 32'(rd_pending_b[0]), 32'd0);
      step(); idle(); #1;
      check("t4_pend_drained", 32'(rd_pending_nb[0]), 32'd0);
      check("t4_data", rd_data_nb[31:0], 32'h79);

      // Simultaneous issue and double writeback, then untracked write
      set_rd(0, 5'd9); issue_addr = 5'd9; issue_valid = 1'b1;
      step(); idle(); #1;
      check("t5_pend_one", 32'(rd_pending_b[0]), 32'd1);
      issue_valid = 1'b1; set_wr(0, 5'd9, 32'hA); set_wr(1, 5'd9, 32'hB); #1;
      check("t5_ready", 32'(issue_ready_b), 32'd1);
      check("t5_pend_same_b", 32'(rd_pending_b[0]), 32'd0);
      check("t5_pend_same_nb", 32'(rd_pending_nb[0]), 32'd1);
      check("t5_bypass", rd_data_b[31:0], 32'hB);
      step(); idle(); #1;
      check("t5_cnt_zero_b", 32'(rd_pending_b[0]), 32'd0);
      check("t5_cnt_zero_nb", 32'(rd_pending_nb[0]), 32'd0);
      set_wr(0, 5'd9, 32'hC);
      step(); idle(); #1;
      check("t5_floor_pend", 32'(rd_pending_nb[0]), 32'd0);
      check("t5_floor_data", rd_data_nb[31:0], 32'hC);
      issue_valid = 1'b1; #1;
      check("t5_floor_ready", 32'(issue_ready_nb), 32'd1);
      step(); idle(); set_wr(0, 5'd9, 32'hD);
      step(); idle(); #1;
      check("t5_no_wrap", 32'(rd_pending_nb[0]), 32'd0);

      // Address beyond NUM_REGS on the 24-register instance
      issue_addr = 5'd30; set_wr(0, 5'd30, 32'h5A5A); set_rd(0, 5'd30); #1;
      check("t7_ready_in_b", 32'(issue_ready_b), 32'd1);
      check("t7_ready_oor_nb", 32'(issue_ready_nb), 32'd0);
      step(); idle(); #1;
      check("t7_rd_b", rd_data_b[31:0], 32'h5A5A);
      check("t7_rd_oor_nb", rd_data_nb[31:0], 32'h0);

`ifdef REGFILE_DEBUG_PORT_EN
      check("t6_dbg_idle", dbg_data_b, 32'h0);
      set_wr(0, 5'd4, 32'hABCD);
      step(); idle(); dbg_addr = 5'd4;
      step(); #1;
      check("t6_dbg_b", dbg_data_b, 32'hABCD);
      check("t6_dbg_nb", dbg_data_nb, 32'hABCD);
      dbg_addr = 5'd0;
      step();
      check("t6_dbg_zero", dbg_data_b, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
